// File: rtl/ir_fetch.sv
// Instruction-fetch stage: issues PC to memory, latches the returned word into IR, advances PC.
// Optional IR_FETCH_COUNT_EN adds a 16-bit count of consumed instructions on fetch_cnt.
module ir_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        run,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [4:0]  imm5,
  output logic [5:0]  offset6,
  output logic [8:0]  pcoff9,
  output logic [10:0] pcoff11,
  output logic [15:0] npc
`ifdef IR_FETCH_COUNT_EN
  , output logic [15:0] fetch_cnt
`endif
);

  localparam logic [1:0] HALT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  state;
  logic [15:0] pc;

  // Request and valid decode straight from state so reset drops them asynchronously.
  assign mem_req  = (state == FETCH);
  assign mem_addr = pc;
  assign ir_valid = (state == FULL);

  assign opcode  = ir[15:12];
  assign imm5    = ir[4:0];
  assign offset6 = ir[5:0];
  assign pcoff9  = ir[8:0];
  assign pcoff11 = ir[10:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= HALT;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
      npc   <= 16'h0000;
    end else if (redirect) begin
      // Redirect wins over any same-cycle memory completion or handshake.
      pc    <= redirect_pc;
      state <= run ? FETCH : HALT;
    end else begin
      case (state)
        HALT:  if (run) state <= FETCH;
        FETCH: if (mem_rdy) begin
          ir    <= mem_rdata;
          npc   <= pc + 16'd1;
          pc    <= pc + 16'd1;
          state <= FULL;
        end
        FULL:  if (ir_ready) state <= run ? FETCH : HALT;
        default: state <= HALT;
      endcase
    end
  end

`ifdef IR_FETCH_COUNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      fetch_cnt <= 16'h0000;
    else if (!redirect && state == FULL && ir_ready)
      fetch_cnt <= fetch_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction-fetch stage for the 16-bit SLC-3 datapath. Issues the PC to memory, waits on a variable-latency read handshake, latches the returned word into IR, and advances PC. It exposes the raw immediate/offset fields that feed the 5-, 6-, 9- and 11-bit sign extenders, and it accepts PC redirects from the branch/JMP logic.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; fetching is enabled while high.
- `redirect`  in  1  single-cycle pulse; load `redirect_pc` and flush.
- `redirect_pc`  in  16  new PC, sampled when `redirect`=1.
- `mem_req`  out  1  read request, held until accepted.
- `mem_addr`  out  16  read address; equals PC while `mem_req`=1.
- `mem_rdy`  in  1  read completes this cycle; `mem_rdata` valid.
- `mem_rdata`  in  16  read data.
- `ir_valid`  out  1  IR holds an instruction not yet consumed.
- `ir_ready`  in  1  downstream decode accepts IR.
- `ir`  out  16  instruction register.
- `opcode`  out  4  `ir[15:12]`.
- `imm5`  out  5  `ir[4:0]`, raw, to the 5-bit extender.
- `offset6`  out  6  `ir[5:0]`, raw.
- `pcoff9`  out  9  `ir[8:0]`, raw.
- `pcoff11`  out  11  `ir[10:0]`, raw.
- `npc`  out  16  PC+1 of the instruction held in IR.

## Operation
- States: HALT, FETCH, FULL. Reset enters HALT.
- Reset values: PC=`RESET_PC`, `ir`=0, all field outputs=0, `npc`=0, `ir_valid`=0, `mem_req`=0.
- HALT: if `run`=1, go to FETCH. Otherwise stay.
- FETCH: `mem_req`=1 and `mem_addr`=PC, both decoded combinationally from state and PC.
  - On `mem_rdy`=1: IR<=`mem_rdata`, `npc`<=PC+1, PC<=PC+1, go to FULL.
  - If `run` drops while `mem_rdy`=0, hold the request anyway; there is no abort except by redirect.
- FULL: `ir_valid`=1 and IR is stable.
  - On `ir_ready`=1: go to FETCH if `run`=1, otherwise HALT.
- Redirect has the highest priority, in any state:
  - PC<=`redirect_pc`.
  - `ir_valid` drops the next cycle.
  - A `mem_rdy` in the same cycle is discarded; IR, `npc` and PC are not updated from it.
  - Next state is FETCH if `run`=1, otherwise HALT.
- PC arithmetic is modulo 2^16: PC=16'hFFFF increments to 16'h0000. `npc` wraps the same way.
- Field outputs are continuous slices of IR. No extension is done here.
- `mem_rdy` while not in FETCH is ignored.

## Timing
- `run` rises in cycle 0 (state HALT): `mem_req`=1 from cycle 1.
- `mem_rdy` in cycle k: `ir_valid`=1 and the new `ir` appear in cycle k+1.
- `ir_ready` in cycle m (state FULL, `run`=1): `ir_valid`=0 and `mem_req`=1 in cycle m+1.
- Best-case throughput is one instruction per 2 cycles, with zero-wait memory and `ir_ready` tied high.
- `redirect` in cycle r: `mem_addr`=`redirect_pc` in cycle r+1 (when `run`=1).
- Reset asserted mid-fetch forces HALT and drops `mem_req` asynchronously. The first request after release is at `RESET_PC`.

## Configuration
- `IR_FETCH_COUNT_EN`: when defined, adds output port `fetch_cnt` (16 bits, reset 0).
  - Increments on each FULL-state `ir_ready` handshake and wraps at 16'hFFFF.
  - Not incremented for instructions flushed by a redirect.
- When not defined, the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with `RESET_PC`=16'h3000, then `run`=1 and memory returning 16'h1261 after 3 wait cycles:
  - `mem_addr`=16'h3000.
  - Then `ir`=16'h1261, `opcode`=4'h1, `imm5`=5'h01, `npc`=16'h3001.
- FULL with `ir_ready`=0 for 5 cycles: `ir_valid` stays 1, `ir` stable, `mem_req`=0 throughout.
- Pulse `redirect` with `redirect_pc`=16'h0040 in the same cycle as `mem_rdy` (data 16'hBEEF):
  - `ir` is not updated to 16'hBEEF.
  - Next `mem_addr`=16'h0040.
- PC=16'hFFFF, fetch completes: `npc`=16'h0000 and next `mem_addr`=16'h0000.
- Drop `run` during FULL, then assert `ir_ready`: state goes to HALT and `mem_req` stays 0 until `run` returns.
- With `IR_FETCH_COUNT_EN` defined, 4 handshakes plus 1 flushed fetch: `fetch_cnt`=4.
